regfile_port_ctrl: RTL and testbench

//  Sequences the single update port of the register file between IDU rename requests and ROB commit writes.

---
 rtl/regfile_port_ctrl_if.sv | 29 ++
 rtl/regfile_port_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_port_ctrl_if.sv
// Handshake bundle between IDU/ROB and regfile_port_ctrl.
// master: IDU/ROB side (drives requests, observes ready/busy).
// slave : regfile_port_ctrl (accepts requests, drives ready/busy).
// Signals: rn_valid/rn_rd/rn_idx/rn_ready (rename), cm_valid/cm_rd/cm_val/cm_ready
// (commit write), rb_req/rb_busy (rollback).
interface regfile_port_ctrl_if #(
  parameter int unsigned ROB_IDX_W = 4
);
  logic                 rn_valid;
  logic [4:0]           rn_rd;
  logic [ROB_IDX_W-1:0] rn_idx;
  logic                 rn_ready;
  logic                 cm_valid;
  logic [4:0]           cm_rd;
  logic [31:0]          cm_val;
  logic                 cm_ready;
  logic                 rb_req;
  logic                 rb_busy;

  modport master (
    output rn_valid, rn_rd, rn_idx, cm_valid, cm_rd, cm_val, rb_req,
    input  rn_ready, cm_ready, rb_busy
  );

  modport slave (
    input  rn_valid, rn_rd, rn_idx, cm_valid, cm_rd, cm_val, rb_req,
    output rn_ready, cm_ready, rb_busy
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: sequences the single regfile update port between IDU
// rename requests and ROB commit writes. Commits are buffered in a small FIFO;
// one regfile operation is issued per cycle. Rollback drains pending commits
// and then issues the src-clear (reg_rb).
// Ports:
//   clk, rst (sync, active-high), rdy (0 = freeze)
//   port      : regfile_port_ctrl_if.slave (rename / commit / rollback handshakes)
//   reg_en, reg_st, reg_rb             : regfile control
//   id_rn_ena, id_rn_rd, id_rn_idx     : regfile rename port
//   rob_wr_ena, rob_wr_rd, rob_wr_val  : regfile write port
//   perf_rn_stall, perf_cq_full        : perf counters
// Build option: define REGCTL_PERF_EN to build saturating perf counters;
// otherwise both perf outputs are tied to 0.
module regfile_port_ctrl #(
  parameter int unsigned CQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned ROB_IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  regfile_port_ctrl_if.slave   port,
  output logic                 reg_en,
  output logic                 reg_st,
  output logic                 reg_rb,
  output logic                 id_rn_ena,
  output logic [4:0]           id_rn_rd,
  output logic [ROB_IDX_W-1:0] id_rn_idx,
  output logic                 rob_wr_ena,
  output logic [4:0]           rob_wr_rd,
  output logic [31:0]          rob_wr_val,
  output logic [31:0]          perf_rn_stall,
  output logic [31:0]          perf_cq_full
);

  localparam int unsigned PTR_W    = $clog2(CQ_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [4:0]          cq_rd_q  [CQ_DEPTH];
  logic [4:0]          cq_rd_d  [CQ_DEPTH];
  logic [31:0]         cq_val_q [CQ_DEPTH];
  logic [31:0]         cq_val_d [CQ_DEPTH];

  logic push, pop, rn_win, force_cm, cq_full, cq_empty;

  assign cq_full  = (count_q == CNT_W'(CQ_DEPTH));
  assign cq_empty = (count_q == '0);
  assign force_cm = cq_full || (starve_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    starve_d      = starve_q;
    cq_rd_d       = cq_rd_q;
    cq_val_d      = cq_val_q;
    push          = 1'b0;
    pop           = 1'b0;
    rn_win        = 1'b0;
    port.rn_ready = 1'b0;
    port.cm_ready = 1'b0;
    port.rb_busy  = (state_q == ST_DRAIN);
    reg_en        = 1'b1;
    reg_st        = !rdy;
    reg_rb        = 1'b0;
    id_rn_ena     = 1'b0;
    id_rn_rd      = '0;
    id_rn_idx     = '0;
    rob_wr_ena    = 1'b0;
    rob_wr_rd     = '0;
    rob_wr_val    = '0;

    if (rdy) begin
      unique case (state_q)
        ST_RUN: begin
          rn_win = port.rn_valid && !force_cm && !port.rb_req;
          // A rename to r0 uses no port, so the head may still drain.
          pop           = !cq_empty && !(rn_win && (port.rn_rd != '0));
          port.rn_ready = rn_win;
          port.cm_ready = !cq_full || pop;
          id_rn_ena     = rn_win && (port.rn_rd != '0);
          if (pop) begin
            starve_d = '0;
          end else if (rn_win && !cq_empty &&
                       (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
          end
          if (port.rb_req) begin
            state_d      = ST_DRAIN;
            port.rb_busy = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (count_q > CNT_W'(1)) begin
            pop = 1'b1;
          end else begin
            reg_rb  = 1'b1;
            pop     = !cq_empty;
            state_d = ST_RUN;
          end
          if (pop) starve_d = '0;
        end
        default: state_d = ST_RUN;
      endcase
    end

    if (id_rn_ena) begin
      id_rn_rd  = port.rn_rd;
      id_rn_idx = port.rn_idx;
    end

    rob_wr_ena = pop;
    if (pop) begin
      rob_wr_rd  = cq_rd_q[rd_ptr_q];
      rob_wr_val = cq_val_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end

    // Writes to r0 are acknowledged but never reach the regfile.
    push = port.cm_valid && port.cm_ready && (port.cm_rd != '0);
    if (push) begin
      cq_rd_d[wr_ptr_q]  = port.cm_rd;
      cq_val_d[wr_ptr_q] = port.cm_val;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      for (int unsigned i = 0; i < CQ_DEPTH; i++) begin
        cq_rd_q[i]  <= '0;
        cq_val_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      cq_rd_q  <= cq_rd_d;
      cq_val_q <= cq_val_d;
    end
  end

`ifdef REGCTL_PERF_EN
  logic [31:0] perf_rn_stall_q, perf_rn_stall_d;
  logic [31:0] perf_cq_full_q, perf_cq_full_d;

  always_comb begin
    perf_rn_stall_d = perf_rn_stall_q;
    perf_cq_full_d  = perf_cq_full_q;
    if (rdy && port.rn_valid && !port.rn_ready && (perf_rn_stall_q != '1))
      perf_rn_stall_d = perf_rn_stall_q + 1'b1;
    if (rdy && cq_full && (perf_cq_full_q != '1))
      perf_cq_full_d = perf_cq_full_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rn_stall_q <= '0;
      perf_cq_full_q  <= '0;
    end else begin
      perf_rn_stall_q <= perf_rn_stall_d;
      perf_cq_full_q  <= perf_cq_full_d;
    end
  end

  assign perf_rn_stall = perf_rn_stall_q;
  assign perf_cq_full  = perf_cq_full_q;
`else
  assign perf_rn_stall = '0;
  assign perf_cq_full  = '0;
`endif

endmodule

// File: tb/tb_regfile_port_ctrl.sv
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        reg_en, reg_st, reg_rb;
  logic        id_rn_ena;
  logic [4:0]  id_rn_rd;
  logic [3:0]  id_rn_idx;
  logic        rob_wr_ena;
  logic [4:0]  rob_wr_rd;
  logic [31:0] rob_wr_val;
  logic [31:0] perf_rn_stall, perf_cq_full;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  regfile_port_ctrl_if #(.ROB_IDX_W(4)) bus ();

  regfile_port_ctrl #(
    .CQ_DEPTH  (4),
    .STARVE_MAX(3),
    .ROB_IDX_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .port         (bus),
    .reg_en       (reg_en),
    .reg_st       (reg_st),
    .reg_rb       (reg_rb),
    .id_rn_ena    (id_rn_ena),
    .id_rn_rd     (id_rn_rd),
    .id_rn_idx    (id_rn_idx),
    .rob_wr_ena   (rob_wr_ena),
    .rob_wr_rd    (rob_wr_rd),
    .rob_wr_val   (rob_wr_val),
    .perf_rn_stall(perf_rn_stall),
    .perf_cq_full (perf_cq_full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next active edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample point for the combinational regfile-side outputs.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rn_valid = 1'b0; bus.rn_rd = '0; bus.rn_idx = '0;
    bus.cm_valid = 1'b0; bus.cm_rd = '0; bus.cm_val = '0;
    bus.rb_req   = 1'b0;
  endtask

  task automatic drive_rn(input logic v, input logic [4:0] rd, input logic [3:0] idx);
    bus.rn_valid = v; bus.rn_rd = rd; bus.rn_idx = idx;
  endtask

  task automatic drive_cm(input logic v, input logic [4:0] rd, input logic [31:0] val);
    bus.cm_valid = v; bus.cm_rd = rd; bus.cm_val = val;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rdy = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    mid();
    check("rst_reg_en", 32'(reg_en), 32'd1);
    check("rst_reg_st", 32'(reg_st), 32'd0);
    check("rst_rb_busy", 32'(bus.rb_busy), 32'd0);
    check("rst_rob_wr_ena", 32'(rob_wr_ena), 32'd0);
    check("rst_id_rn_ena", 32'(id_rn_ena), 32'd0);
    check("rst_perf_stall", perf_rn_stall, 32'd0);
    check("rst_perf_full", perf_cq_full, 32'd0);
    cyc();

    // Reset in the middle of a drain drops queued commits
    for (int i = 0; i < 3; i++) begin
      drive_rn(1'b1, 5'd1, 4'd0);
      drive_cm(1'b1, 5'(20 + i), 32'(32'h200 + i));
      cyc();
    end
    idle();
    bus.rb_req = 1'b1;
    mid();
    check("rstdrain_rb_busy_req", 32'(bus.rb_busy), 32'd1);
    check("rstdrain_pop_rd", 32'(rob_wr_rd), 32'd20);
    cyc();
    bus.rb_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mid();
    check("rstdrain_rb_busy", 32'(bus.rb_busy), 32'd0);
    check("rstdrain_no_write", 32'(rob_wr_ena), 32'd0);
    check("rstdrain_reg_rb", 32'(reg_rb), 32'd0);
    cyc();
    mid();
    check("rstdrain_still_empty", 32'(rob_wr_ena), 32'd0);
    cyc();

    // 1: lone commit is written the following cycle, never same cycle
    drive_cm(1'b1, 5'd3, 32'h55);
    mid();
    check("t1_cm_ready", 32'(bus.cm_ready), 32'd1);
    check("t1_no_bypass", 32'(rob_wr_ena), 32'd0);
    cyc();
    idle();
    mid();
    check("t1_wr_ena", 32'(rob_wr_ena), 32'd1);
    check("t1_wr_rd", 32'(rob_wr_rd), 32'd3);
    check("t1_wr_val", rob_wr_val, 32'h55);
    cyc();
    mid();
    check("t1_empty_after", 32'(rob_wr_ena), 32'd0);
    cyc();

    // 2: rename with empty FIFO issues same cycle
    drive_rn(1'b1, 5'd5, 4'd2);
    mid();
    check("t2_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("t2_id_rn_ena", 32'(id_rn_ena), 32'd1);
    check("t2_id_rn_rd", 32'(id_rn_rd), 32'd5);
    check("t2_id_rn_idx", 32'(id_rn_idx), 32'd2);
    cyc();
    idle();

    // Freeze: rdy=0 blocks everything
    drive_cm(1'b1, 5'd10, 32'hAA);
    cyc();
    rdy = 1'b0;
    drive_rn(1'b1, 5'd7, 4'd3);
    for (int i = 0; i < 2; i++) begin
      mid();
      check("frz_reg_st", 32'(reg_st), 32'd1);
      check("frz_cm_ready", 32'(bus.cm_ready), 32'd0);
      check("frz_rn_ready", 32'(bus.rn_ready), 32'd0);
      check("frz_rob_wr_ena", 32'(rob_wr_ena), 32'd0);
      check("frz_id_rn_ena", 32'(id_rn_ena), 32'd0);
      cyc();
    end
    rdy = 1'b1;
    idle();
    mid();
    check("frz_release_reg_st", 32'(reg_st), 32'd0);
    check("frz_release_wr_rd", 32'(rob_wr_rd), 32'd10);
    check("frz_release_wr_val", rob_wr_val, 32'hAA);
    cyc();

    // 3: starvation limit forces the queued commit on the 4th rename cycle
    drive_rn(1'b1, 5'd6, 4'd1);
    drive_cm(1'b1, 5'd7, 32'h77);
    mid();
    check("t3_first_rn_ready", 32'(bus.rn_ready), 32'd1);
    cyc();
    drive_cm(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t3_rn_wins", 32'(bus.rn_ready), 32'd1);
      check("t3_no_write", 32'(rob_wr_ena), 32'd0);
      cyc();
    end
    mid();
    check("t3_forced_rn_ready", 32'(bus.rn_ready), 32'd0);
    check("t3_forced_id_ena", 32'(id_rn_ena), 32'd0);
    check("t3_forced_wr_ena", 32'(rob_wr_ena), 32'd1);
    check("t3_forced_wr_rd", 32'(rob_wr_rd), 32'd7);
    check("t3_forced_wr_val", rob_wr_val, 32'h77);
    cyc();
    idle();

    // 4: fill FIFO under rename pressure, full FIFO pops every cycle
    drive_rn(1'b1, 5'd9, 4'd4);
    for (int i = 1; i <= 4; i++) begin
      drive_cm(1'b1, 5'(i), 32'(32'h100 + i));
      mid();
      check("t4_fill_cm_ready", 32'(bus.cm_ready), 32'd1);
      check("t4_fill_rn_ready", 32'(bus.rn_ready), 32'd1);
      check("t4_fill_no_write", 32'(rob_wr_ena), 32'd0);
      cyc();
    end
    for (int i = 1; i <= 3; i++) begin
      if (i <= 2) drive_cm(1'b1, 5'(i + 4), 32'(32'h104 + i));
      else        drive_cm(1'b0, 5'd0, 32'h0);
      mid();
      check("t4_full_cm_ready", 32'(bus.cm_ready), 32'd1);
      check("t4_full_rn_ready", 32'(bus.rn_ready), 32'd0);
      check("t4_full_wr_ena", 32'(rob_wr_ena), 32'd1);
      check("t4_full_wr_rd", 32'(rob_wr_rd), 32'(i));
      check("t4_full_wr_val", rob_wr_val, 32'(32'h100 + i));
      cyc();
    end
    mid();
    check("t4_notfull_rn_wins", 32'(bus.rn_ready), 32'd1);
    check("t4_notfull_no_write", 32'(rob_wr_ena), 32'd0);
    cyc();
    idle();
    for (int i = 4; i <= 6; i++) begin
      mid();
      check("t4_drain_wr_rd", 32'(rob_wr_rd), 32'(i));
      check("t4_drain_wr_val", rob_wr_val, 32'(32'h100 + i));
      cyc();
    end
    mid();
    check("t4_empty", 32'(rob_wr_ena), 32'd0);
    cyc();

    // 5: rollback with 3 queued commits
    for (int i = 0; i < 3; i++) begin
      drive_rn(1'b1, 5'd2, 4'd5);
      drive_cm(1'b1, 5'(11 + i), 32'(32'h300 + i));
      cyc();
    end
    idle();
    bus.rb_req = 1'b1;
    mid();
    check("t5_req_rb_busy", 32'(bus.rb_busy), 32'd1);
    check("t5_req_wr_rd", 32'(rob_wr_rd), 32'd11);
    check("t5_req_reg_rb", 32'(reg_rb), 32'd0);
    cyc();
    // A second request during drain must be ignored.
    mid();
    check("t5_d1_rb_busy", 32'(bus.rb_busy), 32'd1);
    check("t5_d1_cm_ready", 32'(bus.cm_ready), 32'd0);
    check("t5_d1_rn_ready", 32'(bus.rn_ready), 32'd0);
    check("t5_d1_wr_rd", 32'(rob_wr_rd), 32'd12);
    check("t5_d1_reg_rb", 32'(reg_rb), 32'd0);
    cyc();
    bus.rb_req = 1'b0;
    mid();
    check("t5_d2_rb_busy", 32'(bus.rb_busy), 32'd1);
    check("t5_d2_reg_rb", 32'(reg_rb), 32'd1);
    check("t5_d2_wr_ena", 32'(rob_wr_ena), 32'd1);
    check("t5_d2_wr_rd", 32'(rob_wr_rd), 32'd13);
    check("t5_d2_wr_val", rob_wr_val, 32'h302);
    cyc();
    mid();
    check("t5_back_rb_busy", 32'(bus.rb_busy), 32'd0);
    check("t5_back_reg_rb", 32'(reg_rb), 32'd0);
    check("t5_back_wr_ena", 32'(rob_wr_ena), 32'd0);
    cyc();

    // Rollback on empty FIFO: same-cycle commit accepted, rename refused
    drive_rn(1'b1, 5'd3, 4'd6);
    drive_cm(1'b1, 5'd14, 32'hEE);
    bus.rb_req = 1'b1;
    mid();
    check("rbe_rn_ready", 32'(bus.rn_ready), 32'd0);
    check("rbe_id_rn_ena", 32'(id_rn_ena), 32'd0);
    check("rbe_cm_ready", 32'(bus.cm_ready), 32'd1);
    check("rbe_no_write", 32'(rob_wr_ena), 32'd0);
    cyc();
    idle();
    mid();
    check("rbe_reg_rb", 32'(reg_rb), 32'd1);
    check("rbe_wr_ena", 32'(rob_wr_ena), 32'd1);
    check("rbe_wr_rd", 32'(rob_wr_rd), 32'd14);
    check("rbe_wr_val", rob_wr_val, 32'hEE);
    cyc();
    mid();
    check("rbe_back_rb_busy", 32'(bus.rb_busy), 32'd0);
    cyc();

    // 6: commit and rename to r0 are accepted but do nothing
    drive_rn(1'b1, 5'd0, 4'd7);
    drive_cm(1'b1, 5'd0, 32'hDEAD);
    mid();
    check("t6_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("t6_cm_ready", 32'(bus.cm_ready), 32'd1);
    check("t6_id_rn_ena", 32'(id_rn_ena), 32'd0);
    cyc();
    idle();
    mid();
    check("t6_not_enqueued", 32'(rob_wr_ena), 32'd0);
    cyc();

    // Rename to r0 leaves the port free for a pop
    drive_rn(1'b1, 5'd4, 4'd1);
    drive_cm(1'b1, 5'd15, 32'hF0);
    cyc();
    drive_cm(1'b0, 5'd0, 32'h0);
    drive_rn(1'b1, 5'd0, 4'd1);
    mid();
    check("r0rn_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("r0rn_id_rn_ena", 32'(id_rn_ena), 32'd0);
    check("r0rn_wr_ena", 32'(rob_wr_ena), 32'd1);
    check("r0rn_wr_rd", 32'(rob_wr_rd), 32'd15);
    cyc();
    idle();
    cyc();

    // Perf counters: stalls = t3 forced(1) + t4 full(3) + rollback refusal(1);
    // full cycles = t4 full(3). Earlier counts were cleared by the mid-drain reset.
    mid();
`ifdef REGCTL_PERF_EN
    check("perf_rn_stall", perf_rn_stall, 32'd5);
    check("perf_cq_full", perf_cq_full, 32'd3);
`else
    check("perf_rn_stall", perf_rn_stall, 32'd0);
    check("perf_cq_full", perf_cq_full, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
